riscv_writeback_arb: RTL and testbench
======================================

# riscv_writeback_arb

Write-side front end of the RISC-V register file. Collects results from the three execution sources (ALU, multiplier, load/store unit) over valid/ready handshakes, buffers them in a DEPTH-entry FIFO, and drives the register file's single write port (we, dreg_num, dreg_val) at one write per cycle. Maintains a 32-bit pending-write scoreboard so the issue stage can detect RAW hazards against results that are not yet in the register file.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- alu_valid / mul_valid / lsu_valid  in  1  source holds a result
- alu_ready / mul_ready / lsu_ready  out  1  result accepted at this edge when valid&ready
- alu_rd / mul_rd / lsu_rd  in  5  destination register
- alu_val / mul_val / lsu_val  in  32  result data
- issue_valid  in  1  instruction with a destination issued this cycle
- issue_rd  in  5  its destination register
- wb_stall  in  1  hold the write port; no FIFO pop
- we  out  1  register-file write enable (registered)
- dreg_num  out  5  write address (registered)
- dreg_val  out  32  write data (registered)
- busy  out  32  bit r set = write to xr pending; busy[0] constant 0
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Arbitration: fixed priority LSU > MUL > ALU; at most one source accepted per cycle. Ready is asserted only to the highest-priority valid source, and only when space is available (see below); all other readies are 0. Ready may depend combinationally on the valids.
- Space available: fifo_count < DEPTH, or fifo_count == DEPTH and a pop occurs this cycle.
- Push: accepted {rd, val} is written at the FIFO tail on the edge.
- Pop: at each edge with FIFO non-empty and wb_stall=0, the head is loaded into dreg_num/dreg_val; we is set to 1 if head rd != 0, else 0 (writes to x0 are discarded but still consume a slot and a cycle). If there is no pop, we=0 and dreg_num/dreg_val hold their values.
- Push and pop in the same cycle are both performed; fifo_count is unchanged. Pointers wrap modulo DEPTH.
- Scoreboard: issue_valid with issue_rd != 0 sets busy[issue_rd] at the edge. A cycle with we=1 clears busy[dreg_num] at the closing edge, which is the same edge at which the register file captures the write. On the same edge, set and clear of the same register resolve to set. issue_rd == 0 is ignored.
- Scoreboard is not a counter: two issues to the same rd before the first retires leave one bit. The first retiring write clears it. Only in-order single-outstanding-per-rd usage is supported; the issue stage guarantees this.

## Timing
- Reset (async, immediate): FIFO empty, fifo_count=0, we=0, dreg_num=0, dreg_val=0, busy=0. Readies are 0 while rst is high; they are combinational from the empty state once rst is low.
- Latency: a result accepted at edge N appears on we/dreg_num/dreg_val after edge N+1 when the FIFO was empty and there is no stall. The register file writes at edge N+2, and busy clears at edge N+2.
- wb_stall for k cycles delays every pending entry by k cycles. With the FIFO full, ready is 0 for all sources.
- Order: entries are written to the register file strictly in acceptance order.
- Reset mid-operation drops all buffered entries and pending busy bits. No partial write is emitted.

## Test plan
- Single ALU result rd=5, val=0xDEADBEEF, FIFO empty: alu_ready=1 at edge 0. we=1, dreg_num=5, dreg_val=0xDEADBEEF during cycle 1. we=0 in cycle 2.
- All three valid, rd 1/2/3: accepts LSU, then MUL, then ALU on consecutive edges. Writes occur in order x1, x2, x3 on three consecutive cycles.
- wb_stall=1 while pushing 5 ALU results with DEPTH=4: four accepted, fifo_count=4, alu_ready=0. Release the stall: one write per cycle, the fifth is accepted on the first pop cycle, and all five retire in order.
- Result with rd=0, val=0x1234: slot consumed and fifo_count decrements, but we stays 0 on that cycle.
- issue_valid with rd=7 sets busy[7]. Result to x7 retires: busy[7]=1 through the we cycle and 0 after. In the we cycle, a re-issue to rd=7 keeps busy[7]=1. issue_rd=0 never sets busy[0].
- Assert rst with 3 entries buffered and busy bits set: outputs, busy, and fifo_count go to 0 immediately. No writes occur after rst is released.

Source files
------------

// File: rtl/riscv_writeback_arb_if.sv
// Bundle of the writeback arbiter's source handshakes, issue/scoreboard
// signals and register-file write port.
interface riscv_writeback_arb_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic          mul_valid;
  logic          lsu_valid;
  logic          alu_ready;
  logic          mul_ready;
  logic          lsu_ready;
  logic [4:0]    alu_rd;
  logic [4:0]    mul_rd;
  logic [4:0]    lsu_rd;
  logic [31:0]   alu_val;
  logic [31:0]   mul_val;
  logic [31:0]   lsu_val;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          wb_stall;
  logic          we;
  logic [4:0]    dreg_num;
  logic [31:0]   dreg_val;
  logic [31:0]   busy;
  logic [CW-1:0] fifo_count;

  // Arbiter side
  modport slave (
    input  alu_valid, mul_valid, lsu_valid,
    input  alu_rd, mul_rd, lsu_rd,
    input  alu_val, mul_val, lsu_val,
    input  issue_valid, issue_rd, wb_stall,
    output alu_ready, mul_ready, lsu_ready,
    output we, dreg_num, dreg_val, busy, fifo_count
  );

  // Sources / issue stage / register-file side
  modport master (
    output alu_valid, mul_valid, lsu_valid,
    output alu_rd, mul_rd, lsu_rd,
    output alu_val, mul_val, lsu_val,
    output issue_valid, issue_rd, wb_stall,
    input  alu_ready, mul_ready, lsu_ready,
    input  we, dreg_num, dreg_val, busy, fifo_count
  );
endinterface

// File: rtl/riscv_writeback_arb.sv
// Register-file write front end: fixed-priority capture of ALU/MUL/LSU
// results into a small FIFO, one registered write per cycle, and a
// pending-write scoreboard for RAW hazard detection at issue.
module riscv_writeback_arb #(
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  riscv_writeback_arb_if.slave wb
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [4:0]    r_rd_mem  [DEPTH];
  logic [31:0]   r_val_mem [DEPTH];
  logic          r_we;
  logic [4:0]    r_dreg_num;
  logic [31:0]   r_dreg_val;
  logic [31:0]   r_busy;

  logic          w_pop;
  logic          w_space;
  logic          w_sel_lsu;
  logic          w_sel_mul;
  logic          w_sel_alu;
  logic          w_push;
  logic [4:0]    w_push_rd;
  logic [31:0]   w_push_val;
  logic [31:0]   w_busy_d;

  assign w_pop   = (r_count != '0) && !wb.wb_stall;
  // A full FIFO can still accept when the head leaves on the same edge.
  assign w_space = (r_count < CW'(DEPTH)) || w_pop;

  // Fixed priority LSU > MUL > ALU; readies held low during reset.
  always_comb begin
    w_sel_lsu = 1'b0;
    w_sel_mul = 1'b0;
    w_sel_alu = 1'b0;
    if (!rst && w_space) begin
      if (wb.lsu_valid) begin
        w_sel_lsu = 1'b1;
      end else if (wb.mul_valid) begin
        w_sel_mul = 1'b1;
      end else if (wb.alu_valid) begin
        w_sel_alu = 1'b1;
      end
    end
  end

  assign wb.lsu_ready = w_sel_lsu;
  assign wb.mul_ready = w_sel_mul;
  assign wb.alu_ready = w_sel_alu;
  assign w_push       = w_sel_lsu | w_sel_mul | w_sel_alu;

  // Mux the accepted source's result onto the FIFO write port.
  always_comb begin
    w_push_rd  = wb.alu_rd;
    w_push_val = wb.alu_val;
    if (w_sel_lsu) begin
      w_push_rd  = wb.lsu_rd;
      w_push_val = wb.lsu_val;
    end else if (w_sel_mul) begin
      w_push_rd  = wb.mul_rd;
      w_push_val = wb.mul_val;
    end
  end

  // Scoreboard next state: retire clears, issue sets, set wins.
  always_comb begin
    w_busy_d = r_busy;
    if (r_we) begin
      w_busy_d[r_dreg_num] = 1'b0;
    end
    if (wb.issue_valid && (wb.issue_rd != 5'd0)) begin
      w_busy_d[wb.issue_rd] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  // FIFO storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_tail]  <= w_push_rd;
      r_val_mem[r_tail] <= w_push_val;
    end
  end

  // Pointers, occupancy, write port and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_we       <= 1'b0;
      r_dreg_num <= 5'd0;
      r_dreg_val <= 32'd0;
      r_busy     <= 32'd0;
    end else begin
      r_busy <= w_busy_d;
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head     <= r_head + AW'(1);
        r_dreg_num <= r_rd_mem[r_head];
        r_dreg_val <= r_val_mem[r_head];
        // Writes to x0 still consume the slot but never assert we.
        r_we       <= (r_rd_mem[r_head] != 5'd0);
      end else begin
        r_we <= 1'b0;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign wb.we         = r_we;
  assign wb.dreg_num   = r_dreg_num;
  assign wb.dreg_val   = r_dreg_val;
  assign wb.busy       = r_busy;
  assign wb.fifo_count = r_count;
endmodule

// File: tb/tb_riscv_writeback_arb.sv
// Directed bench for riscv_writeback_arb: a cycle-by-cycle vector table
// plus hand-written reset-mid-flight and full-FIFO stall sequences.
module tb_riscv_writeback_arb;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  riscv_writeback_arb_if #(.DEPTH(4)) bus ();

  riscv_writeback_arb #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  vld;     // {lsu, mul, alu}
    logic [4:0]  l_rd;
    logic [4:0]  m_rd;
    logic [4:0]  a_rd;
    logic [31:0] a_val;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic [2:0]  e_rdy;   // {lsu, mul, alu}, before the edge
    logic        e_we;    // remaining fields: after the edge
    logic [4:0]  e_num;
    logic [31:0] e_val;
    logic [2:0]  e_cnt;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] vld, logic [4:0] l_rd, logic [4:0] m_rd,
                              logic [4:0] a_rd, logic [31:0] a_val, logic iss_v,
                              logic [4:0] iss_rd, logic [2:0] e_rdy, logic e_we,
                              logic [4:0] e_num, logic [31:0] e_val, logic [2:0] e_cnt,
                              logic [31:0] e_busy);
    vec_t v;
    v.vld = vld; v.l_rd = l_rd; v.m_rd = m_rd; v.a_rd = a_rd; v.a_val = a_val;
    v.iss_v = iss_v; v.iss_rd = iss_rd; v.e_rdy = e_rdy; v.e_we = e_we;
    v.e_num = e_num; v.e_val = e_val; v.e_cnt = e_cnt; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdy3();
    return {29'd0, bus.lsu_ready, bus.mul_ready, bus.alu_ready};
  endfunction

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.mul_valid = 1'b0; bus.lsu_valid = 1'b0;
    bus.alu_rd = 5'd0; bus.mul_rd = 5'd0; bus.lsu_rd = 5'd0;
    bus.alu_val = 32'd0; bus.mul_val = 32'd0; bus.lsu_val = 32'd0;
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0; bus.wb_stall = 1'b0;
  endtask

  initial begin
    int n_push;
    int n_wr;
    logic took;
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_rd = 5'd9;

    // Reset state, with a valid source present
    #12;
    chk("reset_we", {31'd0, bus.we}, 32'd0);
    chk("reset_num", {27'd0, bus.dreg_num}, 32'd0);
    chk("reset_val", bus.dreg_val, 32'd0);
    chk("reset_cnt", {29'd0, bus.fifo_count}, 32'd0);
    chk("reset_busy", bus.busy, 32'd0);
    chk("reset_ready", rdy3(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    //            vld     l  m  a  a_val         iv ird  rdy     we num e_val         cnt busy
    tbl.push_back(mk(3'b001, 0, 0, 5, 32'hDEADBEEF, 0, 0, 3'b001, 0, 0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        0, 0, 3'b000, 1, 5, 32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        0, 0, 3'b000, 0, 5, 32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(mk(3'b111, 1, 2, 3, 32'h33,       0, 0, 3'b100, 0, 5, 32'hDEADBEEF, 1, 32'h0));
    tbl.push_back(mk(3'b011, 0, 2, 3, 32'h33,       0, 0, 3'b010, 1, 1, 32'hA0000001, 1, 32'h0));
    tbl.push_back(mk(3'b001, 0, 0, 3, 32'h33,       0, 0, 3'b001, 1, 2, 32'hB0000002, 1, 32'h0));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        0, 0, 3'b000, 1, 3, 32'h33,       0, 32'h0));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        0, 0, 3'b000, 0, 3, 32'h33,       0, 32'h0));
    tbl.push_back(mk(3'b001, 0, 0, 0, 32'h1234,     0, 0, 3'b001, 0, 3, 32'h33,       1, 32'h0));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        0, 0, 3'b000, 0, 0, 32'h1234,     0, 32'h0));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        1, 7, 3'b000, 0, 0, 32'h1234,     0, 32'h80));
    tbl.push_back(mk(3'b001, 0, 0, 7, 32'h77,       1, 0, 3'b001, 0, 0, 32'h1234,     1, 32'h80));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        0, 0, 3'b000, 1, 7, 32'h77,       0, 32'h80));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        0, 0, 3'b000, 0, 7, 32'h77,       0, 32'h0));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        1, 7, 3'b000, 0, 7, 32'h77,       0, 32'h80));
    tbl.push_back(mk(3'b001, 0, 0, 7, 32'h99,       0, 0, 3'b001, 0, 7, 32'h77,       1, 32'h80));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        0, 0, 3'b000, 1, 7, 32'h99,       0, 32'h80));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        1, 7, 3'b000, 0, 7, 32'h99,       0, 32'h80));
    tbl.push_back(mk(3'b000, 0, 0, 0, 32'h0,        0, 0, 3'b000, 0, 7, 32'h99,       0, 32'h80));

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.lsu_valid = tbl[i].vld[2];
      bus.mul_valid = tbl[i].vld[1];
      bus.alu_valid = tbl[i].vld[0];
      bus.lsu_rd = tbl[i].l_rd;
      bus.mul_rd = tbl[i].m_rd;
      bus.alu_rd = tbl[i].a_rd;
      bus.lsu_val = 32'hA000_0000 | {27'd0, tbl[i].l_rd};
      bus.mul_val = 32'hB000_0000 | {27'd0, tbl[i].m_rd};
      bus.alu_val = tbl[i].a_val;
      bus.issue_valid = tbl[i].iss_v;
      bus.issue_rd = tbl[i].iss_rd;
      #1;
      chk($sformatf("row%0d_ready", i), rdy3(), {29'd0, tbl[i].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_we", i), {31'd0, bus.we}, {31'd0, tbl[i].e_we});
      chk($sformatf("row%0d_num", i), {27'd0, bus.dreg_num}, {27'd0, tbl[i].e_num});
      chk($sformatf("row%0d_val", i), bus.dreg_val, tbl[i].e_val);
      chk($sformatf("row%0d_cnt", i), {29'd0, bus.fifo_count}, {29'd0, tbl[i].e_cnt});
      chk($sformatf("row%0d_busy", i), bus.busy, tbl[i].e_busy);
    end

    // Reset mid-operation: three buffered entries, busy bits 7 and 9 set
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_inputs();
      bus.wb_stall = 1'b1;
      bus.alu_valid = 1'b1;
      bus.alu_rd = 5'(20 + k);
      bus.alu_val = 32'h2000 + 32'(k);
      bus.issue_valid = (k == 0);
      bus.issue_rd = 5'd9;
      #1;
      chk($sformatf("rstseq_ready%0d", k), {31'd0, bus.alu_ready}, 32'd1);
      @(posedge clk);
    end
    #1;
    chk("rstseq_cnt_before", {29'd0, bus.fifo_count}, 32'd3);
    chk("rstseq_busy_before", bus.busy, 32'h280);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rstseq_cnt", {29'd0, bus.fifo_count}, 32'd0);
    chk("rstseq_busy", bus.busy, 32'd0);
    chk("rstseq_we", {31'd0, bus.we}, 32'd0);
    chk("rstseq_num", {27'd0, bus.dreg_num}, 32'd0);
    chk("rstseq_val", bus.dreg_val, 32'd0);
    chk("rstseq_ready", rdy3(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_we%0d", k), {31'd0, bus.we}, 32'd0);
      chk($sformatf("post_rst_cnt%0d", k), {29'd0, bus.fifo_count}, 32'd0);
    end

    // Full FIFO under stall, then release: fifth accepted on first pop cycle
    n_push = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.wb_stall = 1'b1;
      bus.alu_valid = 1'b1;
      bus.alu_rd = 5'(10 + n_push);
      bus.alu_val = 32'h500 + 32'(n_push);
      #1;
      took = bus.alu_ready;
      chk($sformatf("stall_ready%0d", k), {31'd0, took}, (k < 4) ? 32'd1 : 32'd0);
      @(posedge clk);
      if (took) n_push++;
      #1;
      chk($sformatf("stall_we%0d", k), {31'd0, bus.we}, 32'd0);
    end
    chk("stall_full_cnt", {29'd0, bus.fifo_count}, 32'd4);
    @(negedge clk);
    bus.wb_stall = 1'b0;
    #1;
    chk("release_ready", {31'd0, bus.alu_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("release_cnt", {29'd0, bus.fifo_count}, 32'd4);
    n_wr = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.we) begin
        chk($sformatf("drain_num%0d", n_wr), {27'd0, bus.dreg_num}, 32'(10 + n_wr));
        chk($sformatf("drain_val%0d", n_wr), bus.dreg_val, 32'h500 + 32'(n_wr));
        n_wr++;
      end
      @(negedge clk);
      bus.alu_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("drain_total", 32'(n_wr), 32'd5);
    chk("drain_cnt", {29'd0, bus.fifo_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
